udp_tx_scheduler: RTL
=====================

UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 12: idle cycles enforced after each frame (inter-frame gap).
REQ-002 Parameter TIMEOUT, default 4096: maximum SEND-state cycles to wait for tx_last before aborting.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester frame request; bit i = requester i.
REQ-006 req_ready  out  2  per-requester accept; request i is consumed on an edge where req_valid[i] && req_ready[i].
REQ-007 req_src_port  in  32  {req1, req0} UDP source ports, 16 b each.
REQ-008 req_dst_port  in  32  {req1, req0} UDP destination ports, 16 b each.
REQ-009 req_length  in  32  {req1, req0} payload lengths, 16 b each.
REQ-010 req_checksum  in  32  {req1, req0} payload checksums, 16 b each.
REQ-011 tx_start  out  1  one-cycle launch pulse, drives the transport layer's axiiv.
REQ-012 protocol_out  out  8  constant 17 (UDP).
REQ-013 src_port_out, dst_port_out, length_out, checksum_out  out  16 each  latched fields of the granted request.
REQ-014 tx_last  in  1  end-of-frame strobe from the transport layer.
REQ-015 grant_id  out  1  index of the requester currently being served.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 tx_done  out  1  one-cycle pulse on normal frame completion.
REQ-018 tx_error  out  1  one-cycle pulse on timeout abort.

Function
REQ-019 The FSM SHALL have states IDLE, START, SEND and GAP.
REQ-020 In IDLE with any req_valid bit set, req_ready SHALL be driven combinationally one-hot for the winner; it SHALL be 0 in all other cycles.
REQ-021 Arbitration SHALL be round-robin: pointer rr = preferred requester. If both are valid, rr wins; if one is valid, it wins.
REQ-022 On an accepting edge, the block SHALL latch the winner's four fields into the *_out registers and set grant_id = winner.
REQ-023 On the same edge, rr SHALL become ~winner and the state SHALL become START.
REQ-024 START SHALL last exactly one cycle with tx_start = 1, then go to SEND; latency from the accepting edge to tx_start high is 1 cycle.
REQ-025 The *_out fields and grant_id SHALL hold stable from START until the next accept.
REQ-026 In SEND, a 16-bit counter SHALL increment each cycle; tx_last = 1 SHALL move the state to GAP and raise tx_done for the next cycle only.
REQ-027 If the SEND counter reaches TIMEOUT-1 without tx_last, the state SHALL move to GAP and tx_error SHALL pulse for one cycle; tx_done SHALL stay 0.
REQ-028 If tx_last and the timeout occur in the same cycle, tx_last SHALL take priority (tx_done only).
REQ-029 tx_last SHALL be ignored outside SEND.
REQ-030 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; with GAP_CYCLES = 0, SEND SHALL go directly to IDLE.
REQ-031 Requests SHALL never be granted outside IDLE; a requester deasserting req_valid before its accept loses nothing and commits nothing.
REQ-032 The SEND and GAP counters SHALL clear on entry to their states.
REQ-033 protocol_out SHALL be the constant 8'd17 at all times, including during reset.

Reset
REQ-034 While rst is high, the block SHALL asynchronously reset: state = IDLE, rr = 0, grant_id = 0, all *_out fields = 0, counters = 0, and tx_start, tx_done, tx_error, busy, req_ready = 0.
REQ-035 rst asserted mid-frame SHALL abort without a tx_done or tx_error pulse.
REQ-036 After rst deasserts, the first accept SHALL occur no earlier than the first rising edge.

Verification
REQ-037 Single request: req_valid = 01, src 0x1234, dst 0x5678, len 0x0010, cksum 0xBEEF.
  - Required: req_ready = 01 for 1 cycle, then tx_start for 1 cycle, with outputs equal to those fields.
  - Then tx_last at SEND cycle 5: tx_done 1 cycle later, busy low exactly 12 cycles after that.
REQ-038 Contention: req_valid = 11 held, after reset.
  - Required grant order 0, 1, 0, 1 across four frames, each completed by tx_last.
  - No tx_start while busy from the previous frame.
REQ-039 Timeout: TIMEOUT = 8, no tx_last.
  - Required: tx_error pulses once, 8 cycles after START, then GAP, then IDLE.
  - tx_done is never asserted.
REQ-040 Boundaries, GAP_CYCLES = 0:
  - tx_last and the timeout in the same cycle -> tx_done only.
  - A tx_last pulse in IDLE -> no output change.
  - A new req_valid accepted on the first cycle back in IDLE.
REQ-041 Reset mid-SEND: assert rst during SEND with grant_id = 1.
  - Required: all outputs = 0 immediately (asynchronous), with no done or error pulse.
  - The next req_valid = 11 is granted to requester 0.

Source files
------------

// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: two-requester round-robin scheduler for UDP frame launches.
// A granted request is latched, launched with a one-cycle tx_start pulse, then
// the block waits for tx_last (or a timeout) and enforces an inter-frame gap.
module udp_tx_scheduler #(
  parameter int GAP_CYCLES = 12,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_src_port,
  input  logic [31:0] req_dst_port,
  input  logic [31:0] req_length,
  input  logic [31:0] req_checksum,
  output logic        tx_start,
  output logic [7:0]  protocol_out,
  output logic [15:0] src_port_out,
  output logic [15:0] dst_port_out,
  output logic [15:0] length_out,
  output logic [15:0] checksum_out,
  input  logic        tx_last,
  output logic        grant_id,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [15:0] SEND_LAST = 16'(TIMEOUT - 1);
  localparam bit          HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [15:0] GAP_LAST  = HAS_GAP ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] send_cnt_q, gap_cnt_q;
  logic        rr_q;
  logic        grant_q;
  logic [15:0] src_q, dst_q, len_q, cks_q;
  logic        tx_start_q, tx_done_q, tx_error_q, busy_q;

  logic        winner_s;
  logic        accept_s;
  logic        timeout_s;

  // Timeout fires on the SEND cycle whose counter value is TIMEOUT-1.
  assign timeout_s = (state_q == SEND) && (send_cnt_q == SEND_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; tx_last only matters in SEND and wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = START; else state_d = IDLE;
      START:   state_d = SEND;
      SEND:    if (tx_last || timeout_s) state_d = HAS_GAP ? GAP : IDLE; else state_d = SEND;
      GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE; else state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  // Arbitration outputs: ready is offered only in IDLE, one-hot to the round-robin winner.
  always_comb begin
    winner_s  = 1'b0;
    req_ready = 2'b00;
    accept_s  = 1'b0;
    if (!rst && (state_q == IDLE) && (req_valid != 2'b00)) begin
      if (req_valid == 2'b11) winner_s = rr_q;
      else                    winner_s = req_valid[1];
      req_ready = winner_s ? 2'b10 : 2'b01;
      accept_s  = 1'b1;
    end else begin
      winner_s  = 1'b0;
      req_ready = 2'b00;
      accept_s  = 1'b0;
    end
  end

  // SEND and GAP cycle counters, cleared whenever their state is (re)entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_cnt_q <= 16'd0;
      gap_cnt_q  <= 16'd0;
    end else begin
      if ((state_q == SEND) && (state_d == SEND)) send_cnt_q <= send_cnt_q + 16'd1;
      else                                        send_cnt_q <= 16'd0;
      if ((state_q == GAP) && (state_d == GAP))   gap_cnt_q  <= gap_cnt_q + 16'd1;
      else                                        gap_cnt_q  <= 16'd0;
    end
  end

  // Grant latch, round-robin pointer and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b0;
      grant_q    <= 1'b0;
      src_q      <= 16'd0;
      dst_q      <= 16'd0;
      len_q      <= 16'd0;
      cks_q      <= 16'd0;
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= accept_s;
      tx_done_q  <= (state_q == SEND) && tx_last;
      tx_error_q <= timeout_s && !tx_last;
      busy_q     <= (state_d != IDLE);
      if (accept_s) begin
        rr_q    <= ~winner_s;
        grant_q <= winner_s;
        src_q   <= winner_s ? req_src_port[31:16] : req_src_port[15:0];
        dst_q   <= winner_s ? req_dst_port[31:16] : req_dst_port[15:0];
        len_q   <= winner_s ? req_length[31:16]   : req_length[15:0];
        cks_q   <= winner_s ? req_checksum[31:16] : req_checksum[15:0];
      end
    end
  end

  assign protocol_out = 8'd17;
  assign tx_start     = tx_start_q;
  assign tx_done      = tx_done_q;
  assign tx_error     = tx_error_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign src_port_out = src_q;
  assign dst_port_out = dst_q;
  assign length_out   = len_q;
  assign checksum_out = cks_q;

endmodule
